multicycle_control_unit: RTL and testbench

Sequencing FSM for the multi-cycle RV32I core. It replaces the single-cycle core's combinational control decode with a state machine that issues IR/MDR/PC/register-file write strobes per phase. It waits on a memory-ready handshake and traps on memory timeout or illegal opcode. It sits between the shared instruction/data memory and the datapath registers (IR, MDR, A, B, ALUOut), and also provides cycle and retired-instruction counters.

---
 rtl/multicycle_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: IF/ID/EX/MEM/WB phase control with memory-ready
// waits, timeout and illegal-opcode traps, plus cycle and retired-instruction counters.
module multicycle_control_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             alu_bcond,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic [1:0]       alu_op_sel,
    output logic             is_ecall,
    output logic             is_halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    localparam logic [6:0] LEGAL_OPS [8] = '{OP_R, OP_I, OP_LOAD, OP_STORE,
                                             OP_BR, OP_JAL, OP_JALR, OP_ECALL};

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR} state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  cycle_count_reg, instret_count_reg;

    logic [7:0] op_match;
    logic       op_legal;
    logic       timeout_hit;
    logic       retire;
    logic       pc_write_int, mem_write_int, ir_write_int, mdr_write_int, reg_write_int;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_legal
            assign op_match[gi] = (opcode == LEGAL_OPS[gi]);
        end
    endgenerate

    assign op_legal = |op_match;

    // The timeout cycle is the MEM_TIMEOUT-th consecutive not-ready cycle.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == TIMEOUT_LAST) && !mem_ready;

    always_comb begin
        state_next    = state_reg;
        retire        = 1'b0;
        pc_write_int  = 1'b0;
        pc_sel        = 2'd0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write_int = 1'b0;
        ir_write_int  = 1'b0;
        mdr_write_int = 1'b0;
        reg_write_int = 1'b0;
        wb_sel        = 2'd0;
        alu_src_b     = 1'b0;
        alu_op_sel    = 2'd0;
        is_ecall      = 1'b0;
        is_halted     = 1'b0;
        mem_err       = 1'b0;
        case (state_reg)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write_int = 1'b1;
                    state_next   = S_ID;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_ID: begin
                if (!op_legal) begin
                    state_next = S_ERR;
                end else if (opcode == OP_ECALL) begin
                    is_ecall = 1'b1;
                    if (halt_req) begin
                        state_next = S_HALT;
                    end else begin
                        pc_write_int = 1'b1;
                        retire       = 1'b1;
                        state_next   = S_IF;
                    end
                end else begin
                    state_next = S_EX;
                end
            end
            S_EX: begin
                alu_src_b  = !(opcode == OP_R || opcode == OP_BR);
                alu_op_sel = (opcode == OP_R || opcode == OP_I) ? 2'd1 :
                             (opcode == OP_BR)                  ? 2'd2 : 2'd0;
                if (opcode == OP_BR) begin
                    pc_write_int = 1'b1;
                    pc_sel       = alu_bcond ? 2'd1 : 2'd0;
                    retire       = 1'b1;
                    state_next   = S_IF;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                iord          = 1'b1;
                mem_read      = (opcode == OP_LOAD);
                mem_write_int = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        mdr_write_int = 1'b1;
                        state_next    = S_WB;
                    end else begin
                        pc_write_int = 1'b1;
                        retire       = 1'b1;
                        state_next   = S_IF;
                    end
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_WB: begin
                reg_write_int = 1'b1;
                pc_write_int  = 1'b1;
                wb_sel        = (opcode == OP_LOAD) ? 2'd1 :
                                (opcode == OP_JAL || opcode == OP_JALR) ? 2'd2 : 2'd0;
                pc_sel        = (opcode == OP_JAL)  ? 2'd1 :
                                (opcode == OP_JALR) ? 2'd2 : 2'd0;
                retire        = 1'b1;
                state_next    = S_IF;
            end
            S_HALT:  is_halted = 1'b1;
            S_ERR:   mem_err   = 1'b1;
            default: state_next = S_ERR;
        endcase
    end

    // Write strobes are suppressed while reset is held, since state already reads IF.
    assign pc_write  = pc_write_int  & reset;
    assign mem_write = mem_write_int & reset;
    assign ir_write  = ir_write_int  & reset;
    assign mdr_write = mdr_write_int & reset;
    assign reg_write = reg_write_int & reset;

    always_comb begin
        wait_cnt_next = '0;
        if ((state_reg == S_IF || state_reg == S_MEM) && !mem_ready && state_next == state_reg)
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= S_IF;
            wait_cnt_reg      <= '0;
            cycle_count_reg   <= '0;
            instret_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_reg != S_HALT && state_reg != S_ERR)
                cycle_count_reg <= cycle_count_reg + CNT_W'(1);
            if (retire)
                instret_count_reg <= instret_count_reg + CNT_W'(1);
        end
    end

    assign cycle_count   = cycle_count_reg;
    assign instret_count = instret_count_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors and counter checks.
module tb_multicycle_control_unit;

    localparam int CNT_W = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    // Packed view: {pc_write, pc_sel, iord, mem_read, mem_write, ir_write, mdr_write,
    //               reg_write, wb_sel, alu_src_b, alu_op_sel, is_ecall, is_halted, mem_err}
    localparam logic [16:0] NONE    = 17'h00000;
    localparam logic [16:0] PCW     = 17'h10000;
    localparam logic [16:0] PCS_IMM = 17'h04000;
    localparam logic [16:0] PCS_ALU = 17'h08000;
    localparam logic [16:0] IORD    = 17'h02000;
    localparam logic [16:0] MRD     = 17'h01000;
    localparam logic [16:0] MWR     = 17'h00800;
    localparam logic [16:0] IRW     = 17'h00400;
    localparam logic [16:0] MDRW    = 17'h00200;
    localparam logic [16:0] REGW    = 17'h00100;
    localparam logic [16:0] WB_MDR  = 17'h00040;
    localparam logic [16:0] WB_PC4  = 17'h00080;
    localparam logic [16:0] SRCB    = 17'h00020;
    localparam logic [16:0] OP_F    = 17'h00008;
    localparam logic [16:0] OP_CMP  = 17'h00010;
    localparam logic [16:0] ECALL   = 17'h00004;
    localparam logic [16:0] HALTED  = 17'h00002;
    localparam logic [16:0] MERR    = 17'h00001;

    logic             clk;
    logic             reset;
    logic [6:0]       opcode;
    logic             alu_bcond;
    logic             halt_req;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mdr_write;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             alu_src_b;
    logic [1:0]       alu_op_sel;
    logic             is_ecall;
    logic             is_halted;
    logic             mem_err;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;

    int n_cmp;
    int n_bad;
    int exp_cyc;
    int exp_ret;

    multicycle_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .alu_bcond     (alu_bcond),
        .halt_req      (halt_req),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .alu_src_b     (alu_src_b),
        .alu_op_sel    (alu_op_sel),
        .is_ecall      (is_ecall),
        .is_halted     (is_halted),
        .mem_err       (mem_err),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] outs();
        return {pc_write, pc_sel, iord, mem_read, mem_write, ir_write, mdr_write,
                reg_write, wb_sel, alu_src_b, alu_op_sel, is_ecall, is_halted, mem_err};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        mem_ready = 1'b1;
        alu_bcond = 1'b0;
        halt_req  = 1'b0;
        next_edge();
        reset   = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        opcode    = OP_R;
        mem_ready = 1'b1;
        alu_bcond = 1'b0;
        halt_req  = 1'b0;
        #3;
        n_cmp++;
        if (outs() !== MRD) begin
            $display("FAIL reset_outputs: got %h expected %h", outs(), MRD);
            n_bad++;
        end
        n_cmp++;
        if (cycle_count !== 0 || instret_count !== 0) begin
            $display("FAIL reset_counters: got cyc=%0d ret=%0d expected 0/0", cycle_count, instret_count);
            n_bad++;
        end
        next_edge();
        reset   = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    task automatic test_r_type();
        logic [16:0] ev [4] = '{MRD | IRW, NONE, OP_F, REGW | PCW};
        opcode    = OP_R;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev[i]) begin
                $display("FAIL r_type cyc%0d: got %h expected %h", i, outs(), ev[i]);
                n_bad++;
            end
            next_edge();
        end
        exp_cyc += 4;
        exp_ret += 1;
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL r_type_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
    endtask

    task automatic test_alu_jump();
        logic [6:0]  ops [3] = '{OP_I, OP_JAL, OP_JALR};
        logic [16:0] ev_ex [3] = '{SRCB | OP_F, SRCB, SRCB};
        logic [16:0] ev_wb [3] = '{REGW | PCW, REGW | WB_PC4 | PCW | PCS_IMM,
                                   REGW | WB_PC4 | PCW | PCS_ALU};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            next_edge();
            next_edge();
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev_ex[k]) begin
                $display("FAIL alu_jump_ex op=%b: got %h expected %h", ops[k], outs(), ev_ex[k]);
                n_bad++;
            end
            next_edge();
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev_wb[k]) begin
                $display("FAIL alu_jump_wb op=%b: got %h expected %h", ops[k], outs(), ev_wb[k]);
                n_bad++;
            end
            next_edge();
        end
        exp_cyc += 12;
        exp_ret += 3;
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL alu_jump_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
    endtask

    task automatic test_load_wait();
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] ev [7]  = '{MRD | IRW, NONE, SRCB, IORD | MRD, IORD | MRD,
                                 IORD | MRD | MDRW, REGW | WB_MDR | PCW};
        opcode = OP_LOAD;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev[i]) begin
                $display("FAIL load_wait cyc%0d: got %h expected %h", i, outs(), ev[i]);
                n_bad++;
            end
            next_edge();
        end
        mem_ready = 1'b1;
        exp_cyc += 7;
        exp_ret += 1;
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL load_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
    endtask

    task automatic test_store();
        logic [16:0] ev [4] = '{MRD | IRW, NONE, SRCB, IORD | MWR | PCW};
        opcode    = OP_STORE;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev[i]) begin
                $display("FAIL store cyc%0d: got %h expected %h", i, outs(), ev[i]);
                n_bad++;
            end
            next_edge();
        end
        exp_cyc += 4;
        exp_ret += 1;
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL store_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
    endtask

    task automatic test_branch();
        logic        bc [2]    = '{1'b1, 1'b0};
        logic [16:0] ev_ex [2] = '{OP_CMP | PCW | PCS_IMM, OP_CMP | PCW};
        opcode    = OP_BR;
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            alu_bcond = bc[k];
            @(negedge clk);
            n_cmp++;
            if (outs() !== (MRD | IRW)) begin
                $display("FAIL branch_if bcond=%0d: got %h expected %h", bc[k], outs(), MRD | IRW);
                n_bad++;
            end
            next_edge();
            next_edge();
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev_ex[k]) begin
                $display("FAIL branch_ex bcond=%0d: got %h expected %h", bc[k], outs(), ev_ex[k]);
                n_bad++;
            end
            next_edge();
        end
        alu_bcond = 1'b0;
        exp_cyc += 6;
        exp_ret += 2;
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL branch_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
    endtask

    task automatic test_ecall_continue();
        opcode    = OP_ECALL;
        halt_req  = 1'b0;
        mem_ready = 1'b1;
        next_edge();
        @(negedge clk);
        n_cmp++;
        if (outs() !== (ECALL | PCW)) begin
            $display("FAIL ecall_continue: got %h expected %h", outs(), ECALL | PCW);
            n_bad++;
        end
        next_edge();
        exp_cyc += 2;
        exp_ret += 1;
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL ecall_continue_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
    endtask

    // Fourth wait cycle is the timeout cycle; mem_ready there completes the fetch.
    task automatic test_timeout_recover();
        logic        rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [16:0] ev [7]  = '{MRD, MRD, MRD, MRD | IRW, NONE, OP_F, REGW | PCW};
        opcode = OP_R;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev[i]) begin
                $display("FAIL timeout_recover cyc%0d: got %h expected %h", i, outs(), ev[i]);
                n_bad++;
            end
            next_edge();
        end
        exp_cyc += 7;
        exp_ret += 1;
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL timeout_recover_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
    endtask

    task automatic test_ecall_halt();
        opcode    = OP_ECALL;
        halt_req  = 1'b1;
        mem_ready = 1'b1;
        next_edge();
        @(negedge clk);
        n_cmp++;
        if (outs() !== ECALL) begin
            $display("FAIL ecall_halt_id: got %h expected %h", outs(), ECALL);
            n_bad++;
        end
        next_edge();
        exp_cyc += 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== HALTED) begin
                $display("FAIL ecall_halted cyc%0d: got %h expected %h", i, outs(), HALTED);
                n_bad++;
            end
            next_edge();
        end
        n_cmp++;
        if (cycle_count !== CNT_W'(exp_cyc) || instret_count !== CNT_W'(exp_ret)) begin
            $display("FAIL halt_counters: got cyc=%0d ret=%0d expected %0d/%0d",
                     cycle_count, instret_count, exp_cyc, exp_ret);
            n_bad++;
        end
        halt_req = 1'b0;
    endtask

    task automatic test_timeout_err();
        opcode    = OP_R;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== MRD) begin
                $display("FAIL timeout_wait cyc%0d: got %h expected %h", i, outs(), MRD);
                n_bad++;
            end
            next_edge();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== MERR) begin
                $display("FAIL timeout_err cyc%0d: got %h expected %h", i, outs(), MERR);
                n_bad++;
            end
            next_edge();
        end
        n_cmp++;
        if (cycle_count !== CNT_W'(4) || instret_count !== CNT_W'(0)) begin
            $display("FAIL timeout_counters: got cyc=%0d ret=%0d expected 4/0", cycle_count, instret_count);
            n_bad++;
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        logic [16:0] ev [4] = '{MRD | IRW, NONE, MERR, MERR};
        opcode    = 7'b0000000;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs() !== ev[i]) begin
                $display("FAIL illegal cyc%0d: got %h expected %h", i, outs(), ev[i]);
                n_bad++;
            end
            next_edge();
        end
        n_cmp++;
        if (cycle_count !== CNT_W'(2) || instret_count !== CNT_W'(0)) begin
            $display("FAIL illegal_counters: got cyc=%0d ret=%0d expected 2/0", cycle_count, instret_count);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid_wb();
        opcode    = OP_R;
        mem_ready = 1'b1;
        next_edge();
        next_edge();
        next_edge();
        @(negedge clk);
        n_cmp++;
        if (outs() !== (REGW | PCW)) begin
            $display("FAIL mid_wb_before: got %h expected %h", outs(), REGW | PCW);
            n_bad++;
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== MRD) begin
            $display("FAIL mid_wb_reset_outputs: got %h expected %h", outs(), MRD);
            n_bad++;
        end
        n_cmp++;
        if (cycle_count !== 0 || instret_count !== 0) begin
            $display("FAIL mid_wb_reset_counters: got cyc=%0d ret=%0d expected 0/0", cycle_count, instret_count);
            n_bad++;
        end
        next_edge();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs() !== (MRD | IRW)) begin
            $display("FAIL mid_wb_refetch: got %h expected %h", outs(), MRD | IRW);
            n_bad++;
        end
        next_edge();
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cyc = 0;
        exp_ret = 0;
        #1;
        test_reset();
        test_r_type();
        test_alu_jump();
        test_load_wait();
        test_store();
        test_branch();
        test_ecall_continue();
        test_timeout_recover();
        test_ecall_halt();
        do_reset();
        test_timeout_err();
        do_reset();
        test_illegal();
        do_reset();
        test_reset_mid_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
